// File: rtl/fig_08c_pixel_flush.sv
// fig_08c_pixel_flush
//   Flush sequencer between the 8-plane pixel bit matrix and game-pak RAM.
//   On start it latches one planar row (64 bits), its per-pixel dirty mask and
//   the row's RAM byte address, then writes one byte per active bitplane.
//   Rows that are only partly dirty are read-modify-written so clean pixels keep
//   their RAM contents. done and clear_n pulse together when the row is committed.
//
// Ports
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start                 flush request, only honoured while idle
//   bpp_mode              0: 2 planes, 1: 4 planes, 2/3: 8 planes
//   base_addr             RAM address of the plane-0 byte of the row
//   dirty                 per-pixel written flags, bit7 = leftmost pixel
//   data                  planar row, plane p byte = data[8p+7:8p]
//   busy                  high from the accepted start until done
//   done                  one-cycle pulse when the row is committed
//   clear_n               one-cycle low pulse with done, clears matrix dirty flags
//   ram_req/ram_we        request (held until ram_ack) and direction (1 = write)
//   ram_addr/ram_wdata    transaction address and write byte, stable under ram_req
//   ram_rdata/ram_ack     read byte and completion strobe from RAM

module fig_08c_pixel_flush #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        bpp_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [7:0]        dirty,
  input  logic [63:0]       data,
  output logic              busy,
  output logic              done,
  output logic              clear_n,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  input  logic              ram_ack
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    GAP,
    FIN
  } state_t;

  state_t            state;
  logic [2:0]        p;
  logic [2:0]        last_p;
  logic [63:0]       data_q;
  logic [7:0]        dirty_q;
  logic [ADDR_W-1:0] base_q;
  logic [7:0]        m;
  logic              after_read;

  // SNES tile interleave: planes come in pairs 16 bytes apart.
  function automatic logic [ADDR_W-1:0] plane_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [2:0] pl);
    logic [ADDR_W-1:0] off;
    off      = '0;
    off[5:4] = pl[2:1];
    off[0]   = pl[0];
    return base + off;
  endfunction

  function automatic logic [7:0] merge_byte(input logic [7:0] d,
                                            input logic [7:0] old,
                                            input logic [7:0] msk);
    return (d & msk) | (old & ~msk);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      p          <= '0;
      last_p     <= '0;
      data_q     <= '0;
      dirty_q    <= '0;
      base_q     <= '0;
      m          <= '0;
      after_read <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      clear_n    <= 1'b1;
      ram_req    <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      done    <= 1'b0;
      clear_n <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            data_q  <= data;
            dirty_q <= dirty;
            base_q  <= base_addr;
            p       <= '0;
            m       <= '0;
            case (bpp_mode)
              2'd0:    last_p <= 3'd1;
              2'd1:    last_p <= 3'd3;
              default: last_p <= 3'd7;
            endcase
            if (dirty == 8'h00) begin
              // Nothing to commit: straight to the done/clear pulse.
              state   <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              clear_n <= 1'b0;
            end else if (dirty == 8'hFF) begin
              state     <= WR;
              busy      <= 1'b1;
              ram_req   <= 1'b1;
              ram_we    <= 1'b1;
              ram_addr  <= base_addr;
              ram_wdata <= data[7:0];
            end else begin
              state    <= RD;
              busy     <= 1'b1;
              ram_req  <= 1'b1;
              ram_we   <= 1'b0;
              ram_addr <= base_addr;
            end
          end
        end

        RD: begin
          if (ram_ack) begin
            m          <= ram_rdata;
            ram_req    <= 1'b0;
            after_read <= 1'b1;
            state      <= GAP;
          end
        end

        WR: begin
          if (ram_ack) begin
            ram_req    <= 1'b0;
            after_read <= 1'b0;
            p          <= p + 3'd1;
            if (p == last_p) begin
              state   <= FIN;
              busy    <= 1'b0;
              done    <= 1'b1;
              clear_n <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end

        GAP: begin
          // p already points at the plane for the next transaction here:
          // unchanged after a read, advanced after a write.
          ram_req  <= 1'b1;
          ram_addr <= plane_addr(base_q, p);
          if (after_read || dirty_q == 8'hFF) begin
            state     <= WR;
            ram_we    <= 1'b1;
            ram_wdata <= merge_byte(data_q[{p, 3'b000} +: 8], m, dirty_q);
          end else begin
            state  <= RD;
            ram_we <= 1'b0;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fig_08c_pixel_flush.sv
module tb_fig_08c_pixel_flush;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  bpp_mode;
  logic [15:0] base_addr;
  logic [7:0]  dirty;
  logic [63:0] data;
  logic        busy, done, clear_n, ram_req, ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        ram_ack;

  fig_08c_pixel_flush #(.ADDR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bpp_mode(bpp_mode),
    .base_addr(base_addr), .dirty(dirty), .data(data), .busy(busy),
    .done(done), .clear_n(clear_n), .ram_req(ram_req), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [2:0]  plane;
  } txn_t;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  d;
  } log_t;

  txn_t expq[$];
  log_t lg[$];

  // Reference model state
  logic        busy_e = 1'b0, done_e = 1'b0;
  logic [63:0] m_data;
  logic [7:0]  m_dirty;
  logic [7:0]  m_rd;
  int          cyc = 0, acc_cyc = 0, done_cyc = 0;
  int          wait_cnt = 0;
  bit          pending = 0;
  bit          rnd_delay = 0;
  bit          stray_ack = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_addr(input logic [15:0] base, input int pl);
    return base + 16'(16 * (pl / 2)) + 16'(pl % 2);
  endfunction

  // Model + scoreboard + RAM responder, all on the falling edge.
  always @(negedge clk) begin
    logic busy_n, done_n;
    logic [7:0] wexp;
    txn_t t;
    int n;
    cyc++;
    if (!reset_n) begin
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_clear_n", 64'(clear_n), 64'(1));
      chk("rst_req", 64'(ram_req), 64'(0));
      chk("rst_we", 64'(ram_we), 64'(0));
      chk("rst_addr", 64'(ram_addr), 64'(0));
      chk("rst_wdata", 64'(ram_wdata), 64'(0));
      expq.delete();
      busy_e   = 1'b0;
      done_e   = 1'b0;
      pending  = 0;
      ram_ack  = 1'b0;
      prev_req = 1'b0;
      prev_ack = 1'b0;
    end else begin
      chk("busy", 64'(busy), 64'(busy_e));
      chk("done", 64'(done), 64'(done_e));
      chk("clear_n", 64'(clear_n), 64'(!done_e));
      if (prev_req && !prev_ack) begin
        chk("hold_req", 64'(ram_req), 64'(1));
        chk("hold_we", 64'(ram_we), 64'(prev_we));
        chk("hold_addr", 64'(ram_addr), 64'(prev_addr));
        if (prev_we) chk("hold_wdata", 64'(ram_wdata), 64'(prev_wdata));
      end
      if (!busy_e) chk("req_idle", 64'(ram_req), 64'(0));
      if (done_e) done_cyc = cyc;
      busy_n  = busy_e;
      done_n  = 1'b0;
      ram_ack = 1'b0;
      if (ram_req) begin
        if (!pending) begin
          pending  = 1;
          wait_cnt = rnd_delay ? int'($urandom_range(0, 5)) : 0;
        end
        if (wait_cnt == 0) begin
          ram_ack = 1'b1;
          pending = 0;
          if (expq.size() == 0) begin
            chk("unexpected_req", 64'(ram_req), 64'(0));
          end else begin
            t = expq.pop_front();
            chk("txn_we", 64'(ram_we), 64'(t.we));
            chk("txn_addr", 64'(ram_addr), 64'(t.addr));
            if (ram_we) begin
              wexp = (m_data[8*int'(t.plane) +: 8] & m_dirty) | (m_rd & ~m_dirty);
              chk("txn_wdata", 64'(ram_wdata), 64'(wexp));
              mem[ram_addr] = ram_wdata;
              lg.push_back('{1'b1, ram_addr, ram_wdata});
            end else begin
              m_rd      = mem[ram_addr];
              ram_rdata = m_rd;
              lg.push_back('{1'b0, ram_addr, m_rd});
            end
            if (expq.size() == 0) begin
              busy_n = 1'b0;
              done_n = 1'b1;
            end
          end
        end else begin
          wait_cnt--;
        end
      end else if (stray_ack) begin
        ram_ack = 1'b1;
      end
      if (start && !busy_e && !done_e) begin
        m_data  = data;
        m_dirty = dirty;
        m_rd    = 8'h00;
        acc_cyc = cyc;
        n = (bpp_mode == 2'd0) ? 2 : (bpp_mode == 2'd1) ? 4 : 8;
        if (dirty != 8'h00) begin
          for (int pl = 0; pl < n; pl++) begin
            if (dirty != 8'hFF) expq.push_back('{1'b0, exp_addr(base_addr, pl), 3'(pl)});
            expq.push_back('{1'b1, exp_addr(base_addr, pl), 3'(pl)});
          end
          busy_n = 1'b1;
        end else begin
          busy_n = 1'b0;
          done_n = 1'b1;
        end
      end
      busy_e     = busy_n;
      done_e     = done_n;
      prev_req   = ram_req;
      prev_ack   = ram_ack;
      prev_we    = ram_we;
      prev_addr  = ram_addr;
      prev_wdata = ram_wdata;
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #2;
      if (!busy_e && !done_e) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic issue(input logic [1:0] b, input logic [15:0] base,
                       input logic [7:0] dm, input logic [63:0] d);
    @(posedge clk); #2;
    lg.delete();
    bpp_mode  = b;
    base_addr = base;
    dirty     = dm;
    data      = d;
    start     = 1'b1;
    @(posedge clk); #2;
    start     = 1'b0;
    // Inputs move on after the start cycle; only latched values may be used.
    data      = ~d;
    dirty     = ~dm;
    base_addr = base ^ 16'h5555;
    bpp_mode  = ~b;
  endtask

  task automatic flush(input logic [1:0] b, input logic [15:0] base,
                       input logic [7:0] dm, input logic [63:0] d);
    issue(b, base, dm, d);
    wait_idle();
  endtask

  logic [15:0] a4 [8];
  logic [15:0] a3 [4];
  int wi;
  bit seen;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset_n = 1'b0; start = 1'b0; bpp_mode = '0; base_addr = '0;
    dirty = '0; data = '0; ram_rdata = '0; ram_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Full mask, 2bpp, zero-wait RAM
    flush(2'd0, 16'h1000, 8'hFF, 64'h0000_0000_0000_A55A);
    chk("t2_count", 64'(lg.size()), 64'(2));
    if (lg.size() == 2) begin
      chk("t2_w0", {47'(0), lg[0].we, lg[0].addr}, {47'(0), 1'b1, 16'h1000});
      chk("t2_d0", 64'(lg[0].d), 64'h5A);
      chk("t2_w1", {47'(0), lg[1].we, lg[1].addr}, {47'(0), 1'b1, 16'h1001});
      chk("t2_d1", 64'(lg[1].d), 64'hA5);
    end
    chk("t2_latency", 64'(done_cyc - acc_cyc), 64'(4));

    // Partial mask, 4bpp read-modify-write
    a3 = '{16'h1000, 16'h1001, 16'h1010, 16'h1011};
    for (int i = 0; i < 4; i++) mem[a3[i]] = 8'h0F;
    flush(2'd1, 16'h1000, 8'hF0, 64'h0000_0000_FFFF_FFFF);
    chk("t3_count", 64'(lg.size()), 64'(8));
    if (lg.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        chk("t3_rd", {47'(0), lg[2*i].we, lg[2*i].addr}, {47'(0), 1'b0, a3[i]});
        chk("t3_rdata", 64'(lg[2*i].d), 64'h0F);
        chk("t3_wr", {47'(0), lg[2*i+1].we, lg[2*i+1].addr}, {47'(0), 1'b1, a3[i]});
        chk("t3_wdata", 64'(lg[2*i+1].d), 64'hFF);
      end
    end
    chk("t3_latency", 64'(done_cyc - acc_cyc), 64'(16));

    // 8bpp, wrapping addresses, random ack latency
    rnd_delay = 1;
    a4 = '{16'hFFE0, 16'hFFE1, 16'hFFF0, 16'hFFF1, 16'h0000, 16'h0001, 16'h0010, 16'h0011};
    flush(2'd2, 16'hFFE0, 8'h81, 64'h0123_4567_89AB_CDEF);
    wi = 0;
    foreach (lg[i]) begin
      if (lg[i].we) begin
        if (wi < 8) chk("t4_addr", 64'(lg[i].addr), 64'(a4[wi]));
        wi++;
      end
    end
    chk("t4_writes", 64'(wi), 64'(8));
    flush(2'd3, 16'hFFE0, 8'hFF, 64'hFEDC_BA98_7654_3210);

    // Empty mask
    rnd_delay = 0;
    flush(2'd2, 16'h3000, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t5_count", 64'(lg.size()), 64'(0));
    chk("t5_latency", 64'(done_cyc - acc_cyc), 64'(1));

    // Start while busy is ignored; post-start input changes are ignored
    issue(2'd0, 16'h2000, 8'hFF, 64'h0000_0000_0000_1234);
    @(posedge clk); #2;
    dirty = 8'h0F; data = 64'hFFFF; base_addr = 16'h4000; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_idle();
    chk("t6_count", 64'(lg.size()), 64'(2));
    if (lg.size() == 2) begin
      chk("t6_a0", 64'(lg[0].addr), 64'h2000);
      chk("t6_d0", 64'(lg[0].d), 64'h34);
      chk("t6_a1", 64'(lg[1].addr), 64'h2001);
      chk("t6_d1", 64'(lg[1].d), 64'h12);
    end

    // Stray acks while no request is outstanding
    stray_ack = 1; rnd_delay = 1;
    flush(2'd1, 16'h5008, 8'h3C, 64'h0000_0000_1122_3344);
    stray_ack = 0;
    flush(2'd0, 16'h6000, 8'hC3, 64'h0000_0000_0000_55AA);
    rnd_delay = 0;

    // Reset in the middle of a write
    issue(2'd2, 16'h7000, 8'hFF, 64'h1111_2222_3333_4444);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      if (ram_req && ram_we) begin
        seen = 1;
        break;
      end
      @(posedge clk); #2;
    end
    chk("t1_found_write", 64'(seen), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_done", 64'(done), 64'(0));
    chk("t1_clear_n", 64'(clear_n), 64'(1));
    chk("t1_req", 64'(ram_req), 64'(0));
    chk("t1_we", 64'(ram_we), 64'(0));
    chk("t1_addr", 64'(ram_addr), 64'(0));
    chk("t1_wdata", 64'(ram_wdata), 64'(0));
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("t1_post_req", 64'(ram_req), 64'(0));
    chk("t1_post_done", 64'(done), 64'(0));
    flush(2'd0, 16'h1000, 8'hFF, 64'h0000_0000_0000_BEEF);
    chk("t1_recover", 64'(lg.size()), 64'(2));

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
